// File: rtl/assert_ctl_responder.sv
// assert_ctl_responder
//
// Responder side of the assertion-control path. It takes ON/OFF/KILL
// commands over a valid/ready channel and keeps a per-scope enable mask.
// Incoming failure events are filtered against that mask. Accepted failures
// are counted per scope and queued as reports for a downstream logger.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ctl_valid/ctl_ready   command handshake; at most one command every 2 cycles
//   ctl_op, ctl_mask      command code (0 ON, 1 OFF, 2 KILL, 3 no-op) and scopes
//   fail_valid/fail_scope assertion failure event; there is no backpressure
//   rpt_valid/rpt_ready   report handshake toward the logger
//   rpt_scope, rpt_count  head report: scope and its count after this failure
//   enabled               current enable mask
//   drop_cnt              failures lost to a full report FIFO (saturating)

module assert_ctl_responder #(
  parameter int NSCOPE  = 8,
  parameter int SCOPE_W = $clog2(NSCOPE),
  parameter int CNT_W   = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctl_valid,
  output logic               ctl_ready,
  input  logic [1:0]         ctl_op,
  input  logic [NSCOPE-1:0]  ctl_mask,
  input  logic               fail_valid,
  input  logic [SCOPE_W-1:0] fail_scope,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [SCOPE_W-1:0] rpt_scope,
  output logic [CNT_W-1:0]   rpt_count,
  output logic [NSCOPE-1:0]  enabled,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_ON   = 2'd0;
  localparam logic [1:0] OP_OFF  = 2'd1;
  localparam logic [1:0] OP_KILL = 2'd2;

  typedef enum logic {IDLE, GAP} state_t;

  state_t             state_q, state_d;
  logic [NSCOPE-1:0]  enabled_q, enabled_d;
  logic [CNT_W-1:0]   cnt_q [NSCOPE];
  logic [CNT_W-1:0]   cnt_d [NSCOPE];
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [SCOPE_W-1:0] fifo_scope_q [DEPTH];
  logic [SCOPE_W-1:0] fifo_scope_d [DEPTH];
  logic [CNT_W-1:0]   fifo_cnt_q [DEPTH];
  logic [CNT_W-1:0]   fifo_cnt_d [DEPTH];
  logic [DEPTH-1:0]   fifo_kill_q, fifo_kill_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic               ctl_accept;
  logic [NSCOPE-1:0]  kill_mask;
  logic               fifo_empty, fifo_full, head_killed, pop;
  logic               fail_hit, push_req, push;
  logic [CNT_W-1:0]   new_cnt;
  logic [AW-1:0]      rd_idx, wr_idx;

  // Control FSM: IDLE accepts a command, GAP always follows an accept.
  always_comb begin
    state_d   = state_q;
    ctl_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ctl_ready = 1'b1;
        if (ctl_valid) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl_accept = ctl_valid & ctl_ready;
    kill_mask  = (ctl_accept && ctl_op == OP_KILL) ? ctl_mask : '0;

    enabled_d = enabled_q;
    if (ctl_accept) begin
      case (ctl_op)
        OP_ON:   enabled_d = enabled_q | ctl_mask;
        OP_OFF:  enabled_d = enabled_q & ~ctl_mask;
        OP_KILL: enabled_d = enabled_q & ~ctl_mask;
        default: enabled_d = enabled_q;
      endcase
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    rd_idx      = rd_ptr_q[AW-1:0];
    wr_idx      = wr_ptr_q[AW-1:0];
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    head_killed = !fifo_empty && fifo_kill_q[rd_idx];
    rpt_valid   = !fifo_empty && !fifo_kill_q[rd_idx];
    rpt_scope   = fifo_scope_q[rd_idx];
    rpt_count   = fifo_cnt_q[rd_idx];
    pop         = (rpt_valid && rpt_ready) || head_killed;

    // A KILL on the failing scope in the same cycle overrides the failure.
    fail_hit = fail_valid && enabled_q[fail_scope];
    push_req = fail_hit && !kill_mask[fail_scope];
    push     = push_req && (!fifo_full || pop);
    new_cnt  = (cnt_q[fail_scope] == '1) ? cnt_q[fail_scope]
                                         : cnt_q[fail_scope] + CNT_W'(1);

    for (int i = 0; i < NSCOPE; i++) begin
      cnt_d[i] = kill_mask[i] ? '0 : cnt_q[i];
    end
    if (push_req) cnt_d[fail_scope] = new_cnt;

    drop_d = drop_q;
    if (push_req && !push && drop_q != '1) drop_d = drop_q + CNT_W'(1);

    // The entry popped this cycle may also get marked, but it is leaving, so
    // the report already handed over is unaffected. A push into the slot
    // being freed overwrites the mark with a fresh, unkilled entry.
    fifo_scope_d = fifo_scope_q;
    fifo_cnt_d   = fifo_cnt_q;
    fifo_kill_d  = fifo_kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_mask[fifo_scope_q[i]]) fifo_kill_d[i] = 1'b1;
    end
    if (push) begin
      fifo_scope_d[wr_idx] = fail_scope;
      fifo_cnt_d[wr_idx]   = new_cnt;
      fifo_kill_d[wr_idx]  = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      enabled_q   <= '1;
      drop_q      <= '0;
      fifo_kill_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < NSCOPE; i++) cnt_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_scope_q[i] <= '0;
        fifo_cnt_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      enabled_q    <= enabled_d;
      drop_q       <= drop_d;
      fifo_kill_q  <= fifo_kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fifo_scope_q <= fifo_scope_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign enabled  = enabled_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_assert_ctl_responder.sv
// tb_assert_ctl_responder
//
// Bench for assert_ctl_responder. Reports the bench expects are queued as
// stimulus is driven; a monitor pops and compares them on every report
// handshake.

module tb_assert_ctl_responder;

  localparam int NSCOPE  = 8;
  localparam int SCOPE_W = 3;
  localparam int CNT_W   = 16;

  localparam logic [1:0] OP_ON   = 2'd0;
  localparam logic [1:0] OP_OFF  = 2'd1;
  localparam logic [1:0] OP_KILL = 2'd2;

  logic               clk;
  logic               rst_n;
  logic               ctl_valid;
  logic               ctl_ready;
  logic [1:0]         ctl_op;
  logic [NSCOPE-1:0]  ctl_mask;
  logic               fail_valid;
  logic [SCOPE_W-1:0] fail_scope;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [SCOPE_W-1:0] rpt_scope;
  logic [CNT_W-1:0]   rpt_count;
  logic [NSCOPE-1:0]  enabled;
  logic [CNT_W-1:0]   drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [SCOPE_W+CNT_W-1:0] expQ[$];

  assert_ctl_responder #(
    .NSCOPE(NSCOPE), .SCOPE_W(SCOPE_W), .CNT_W(CNT_W), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_op(ctl_op), .ctl_mask(ctl_mask),
    .fail_valid(fail_valid), .fail_scope(fail_scope),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_scope(rpt_scope), .rpt_count(rpt_count),
    .enabled(enabled), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reports are sampled on the falling edge, half a cycle from the handshake edge.
  always @(negedge clk) begin
    if (rst_n && rpt_valid && rpt_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rpt", {13'd0, rpt_scope, rpt_count}, 32'd0);
      end else begin
        checkOutput("rpt", {13'd0, rpt_scope, rpt_count}, {13'd0, expQ.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of failure/command stimulus, then returns both to idle.
  task automatic applyStimulus(input logic fv, input logic [SCOPE_W-1:0] fs,
                               input logic cv, input logic [1:0] op,
                               input logic [NSCOPE-1:0] mask);
    fail_valid = fv;
    fail_scope = fs;
    ctl_valid  = cv;
    ctl_op     = op;
    ctl_mask   = mask;
    tick();
    fail_valid = 1'b0;
    ctl_valid  = 1'b0;
  endtask

  task automatic sendFail(input logic [SCOPE_W-1:0] s);
    applyStimulus(1'b1, s, 1'b0, 2'd3, '0);
  endtask

  task automatic sendCmd(input logic [1:0] op, input logic [NSCOPE-1:0] mask);
    applyStimulus(1'b0, '0, 1'b1, op, mask);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expectReport(input logic [SCOPE_W-1:0] s, input logic [CNT_W-1:0] c);
    expQ.push_back({s, c});
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 60 && expQ.size() != 0; i++) tick();
    idleCycles(3);
    checkOutput(tag, expQ.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ctl_valid = 1'b0; ctl_op = 2'd3; ctl_mask = '0;
    fail_valid = 1'b0; fail_scope = '0; rpt_ready = 1'b1;
    #12;
    checkOutput("rst_rpt_valid", rpt_valid, 1'b0);
    checkOutput("rst_ctl_ready", ctl_ready, 1'b1);
    checkOutput("rst_enabled", enabled, 8'hFF);
    checkOutput("rst_drop", drop_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    idleCycles(2);

    // Three consecutive failures on scope 3, report valid the cycle after the first.
    expectReport(3, 1); expectReport(3, 2); expectReport(3, 3);
    sendFail(3);
    checkOutput("t1_first_valid", rpt_valid, 1'b1);
    sendFail(3);
    sendFail(3);
    waitDrain("t1_drain");
    checkOutput("t1_drop", drop_cnt, 16'd0);

    // OFF scopes 2,3 then failures on 2,3,4; re-enable scope 2.
    sendCmd(OP_OFF, 8'h0C);
    idleCycles(1);
    checkOutput("t2_enabled_off", enabled, 8'hF3);
    expectReport(4, 1);
    sendFail(2); sendFail(3); sendFail(4);
    sendCmd(OP_ON, 8'h04);
    idleCycles(1);
    checkOutput("t2_enabled_on", enabled, 8'hF7);
    expectReport(2, 1);
    sendFail(2);
    waitDrain("t2_drain");

    // Overflow: six failures on scope 1 with the sink stalled.
    rpt_ready = 1'b0;
    for (int i = 0; i < 6; i++) sendFail(1);
    idleCycles(2);
    checkOutput("t3_drop", drop_cnt, 16'd2);
    checkOutput("t3_hold_valid", rpt_valid, 1'b1);
    checkOutput("t3_hold_scope", rpt_scope, 3'd1);
    checkOutput("t3_hold_count", rpt_count, 16'd1);
    for (int c = 1; c <= 4; c++) expectReport(1, CNT_W'(c));
    rpt_ready = 1'b1;
    waitDrain("t3_drain");
    expectReport(1, 7);
    sendFail(1);
    waitDrain("t3_after");

    // KILL scope 5 with (5,1),(6,1),(5,2) queued.
    rpt_ready = 1'b0;
    sendFail(5); sendFail(6); sendFail(5);
    sendCmd(OP_KILL, 8'h20);
    idleCycles(1);
    checkOutput("t4_enabled_kill", enabled, 8'hD7);
    expectReport(6, 1);
    rpt_ready = 1'b1;
    waitDrain("t4_drain");
    sendFail(5);
    idleCycles(3);
    checkOutput("t4_filtered", rpt_valid, 1'b0);
    sendCmd(OP_ON, 8'h20);
    idleCycles(1);
    expectReport(5, 1);
    sendFail(5);
    waitDrain("t4_after");

    // Back-to-back commands: only the 1st and 3rd are accepted.
    for (int i = 0; i < 4; i++) begin
      ctl_valid = 1'b1;
      ctl_op    = OP_OFF;
      ctl_mask  = 8'h01 << i;
      checkOutput($sformatf("t5_ready%0d", i), ctl_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    ctl_valid = 1'b0;
    idleCycles(1);
    checkOutput("t5_enabled", enabled, 8'hF2);
    sendCmd(OP_ON, 8'hFF);
    idleCycles(1);

    // Same-cycle KILL and failure on scope 1: no report, counter cleared.
    applyStimulus(1'b1, 3'd1, 1'b1, OP_KILL, 8'h02);
    idleCycles(2);
    checkOutput("t5_kill_no_rpt", rpt_valid, 1'b0);
    checkOutput("t5_kill_enabled", enabled, 8'hFD);
    sendCmd(OP_ON, 8'h02);
    idleCycles(1);
    expectReport(1, 1);
    sendFail(1);
    waitDrain("t5_kill_after");

    // Same-cycle OFF and failure: counted under the old mask.
    expectReport(6, 2);
    applyStimulus(1'b1, 3'd6, 1'b1, OP_OFF, 8'h40);
    sendFail(6);
    waitDrain("t5_off_fail");
    checkOutput("t5_off_enabled", enabled, 8'hBF);
    sendCmd(OP_ON, 8'h40);
    idleCycles(1);

    // Reset in the middle of operation with reports queued and mask cleared.
    rpt_ready = 1'b0;
    sendFail(0); sendFail(0); sendFail(0);
    sendCmd(OP_OFF, 8'hFF);
    idleCycles(1);
    checkOutput("t6_pre_enabled", enabled, 8'h00);
    checkOutput("t6_pre_valid", rpt_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", rpt_valid, 1'b0);
    checkOutput("t6_rst_enabled", enabled, 8'hFF);
    checkOutput("t6_rst_ready", ctl_ready, 1'b1);
    checkOutput("t6_rst_drop", drop_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t6_post_valid", rpt_valid, 1'b0);
    checkOutput("t6_post_enabled", enabled, 8'hFF);
    checkOutput("t6_post_ready", ctl_ready, 1'b1);
    checkOutput("t6_post_drop", drop_cnt, 16'd0);
    rpt_ready = 1'b1;
    expectReport(0, 1);
    sendFail(0);
    waitDrain("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
